// File: rtl/cpu_disp_pkg.sv
// rtl/cpu_disp_pkg.sv - shared state type and segment constants for the display driver
package cpu_disp_pkg;

   typedef enum logic {
      DISP_RUN    = 1'b0,
      DISP_HALTED = 1'b1
   } disp_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
   localparam logic [6:0] SEG_LUT [0:15] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/cpu_disp_hex2seg.sv
// rtl/cpu_disp_hex2seg.sv - combinational 4-bit to active-low seven-segment decoder
module cpu_disp_hex2seg
   import cpu_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   assign seg_n = SEG_LUT[nibble];

endmodule

// File: rtl/cpu_disp_driver.sv
// rtl/cpu_disp_driver.sv - 8-digit multiplexed seven-segment driver with frame snapshot and halt capture
// Optional leading-zero blanking is enabled by defining CPU_DISP_BLANK_EN.
module cpu_disp_driver
   import cpu_disp_pkg::*;
#(
   parameter int CLK_DIV = 50000,
   parameter int DIGITS  = 8
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic [31:0] display,
   input  logic [31:0] cycle_count,
   input  logic        halt,
   input  logic        src_sel,
   input  logic        freeze,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [7:0]  an_n,
   output logic [31:0] shown,
   output logic        halted_seen
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [PW-1:0] prescaler;
   logic [2:0]    index;
   logic          tick;
   logic          frame_end;
   logic [31:0]   halt_disp;
   logic [31:0]   halt_cyc;
   logic [31:0]   src_val;
   logic [4:0]    nib_lo;
   logic [3:0]    nibble;
   logic [6:0]    dec_seg;
   logic [6:0]    seg_d;
   logic          dp_d;
   logic          capture;

   disp_state_t   state;
   disp_state_t   state_d;

   assign tick      = (prescaler == PW'(CLK_DIV - 1));
   assign frame_end = tick && (index == 3'(DIGITS - 1));
   assign nib_lo    = {index, 2'b00};
   assign nibble    = shown[nib_lo +: 4];

   // Halted frames show the frozen snapshots; src_sel still picks which one.
   assign src_val = (state == DISP_HALTED) ? (src_sel ? halt_cyc    : halt_disp)
                                           : (src_sel ? cycle_count : display);

   cpu_disp_hex2seg u_hex2seg (
      .nibble (nibble),
      .seg_n  (dec_seg)
   );

`ifdef CPU_DISP_BLANK_EN
   logic [31:0] upper;
   logic        blank;

   assign upper = shown >> nib_lo;
   assign blank = (index != 3'd0) && (upper == 32'd0);

   always_comb begin
      seg_d = dec_seg;
      dp_d  = !(halted_seen && (index == 3'd0));
      if (blank) begin
         seg_d = SEG_BLANK;
         dp_d  = 1'b1;
      end
   end
`else
   always_comb begin
      seg_d = dec_seg;
      dp_d  = !(halted_seen && (index == 3'd0));
   end
`endif

   always_comb begin
      state_d = state;
      capture = 1'b0;
      case (state)
         DISP_RUN: begin
            if (halt) begin
               capture = 1'b1;
               state_d = DISP_HALTED;
            end
         end
         DISP_HALTED: state_d = DISP_HALTED;
         default:     state_d = DISP_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state <= DISP_RUN;
      end else begin
         state <= state_d;
      end
   end

   assign halted_seen = (state == DISP_HALTED);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         prescaler <= '0;
         index     <= '0;
         shown     <= '0;
         halt_disp <= '0;
         halt_cyc  <= '0;
         an_n      <= 8'hFF;
         seg_n     <= SEG_BLANK;
         dp_n      <= 1'b1;
      end else begin
         prescaler <= tick ? '0 : prescaler + PW'(1);
         if (tick) begin
            index <= index + 3'd1;
         end
         if (frame_end && !freeze) begin
            shown <= src_val;
         end
         if (capture) begin
            halt_disp <= display;
            halt_cyc  <= cycle_count;
         end
         an_n  <= ~(8'd1 << index);
         seg_n <= seg_d;
         dp_n  <= dp_d;
      end
   end

endmodule

// File: tb/tb_cpu_disp_driver.sv
// tb/tb_cpu_disp_driver.sv - self-checking bench for cpu_disp_driver against a cycle-count reference model
module tb_cpu_disp_driver;

   localparam int CLK_DIV = 4;
   localparam int FRAME   = CLK_DIV * 8;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic [31:0] display = '0;
   logic [31:0] cycle_count = '0;
   logic        halt = 1'b0;
   logic        src_sel = 1'b0;
   logic        freeze = 1'b0;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [7:0]  an_n;
   logic [31:0] shown;
   logic        halted_seen;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cpu_disp_driver #(.CLK_DIV(CLK_DIV), .DIGITS(8)) dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .display     (display),
      .cycle_count (cycle_count),
      .halt        (halt),
      .src_sel     (src_sel),
      .freeze      (freeze),
      .seg_n       (seg_n),
      .dp_n        (dp_n),
      .an_n        (an_n),
      .shown       (shown),
      .halted_seen (halted_seen)
   );

   // Reference model: everything derives from the number of clocks since reset release.
   int          cyc;
   int          m_idx;
   logic [31:0] m_shown, m_hd, m_hc, m_upper;
   logic        m_halted;
   logic [7:0]  m_an;
   logic [6:0]  m_seg;
   logic        m_dp;

   function automatic logic [6:0] hex_ref(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cyc = 0; m_shown = '0; m_hd = '0; m_hc = '0; m_halted = 1'b0;
         m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
      end else begin
         m_idx   = (cyc / CLK_DIV) % 8;
         m_upper = m_shown >> (4 * m_idx);
         m_an    = ~(8'd1 << m_idx);
         m_seg   = hex_ref(m_upper[3:0]);
         m_dp    = !(m_halted && m_idx == 0);
`ifdef CPU_DISP_BLANK_EN
         if (m_idx != 0 && m_upper == 32'd0) begin
            m_seg = 7'h7F;
            m_dp  = 1'b1;
         end
`endif
         if ((cyc % FRAME) == FRAME - 1 && !freeze)
            m_shown = m_halted ? (src_sel ? m_hc : m_hd) : (src_sel ? cycle_count : display);
         if (!m_halted && halt) begin
            m_hd = display; m_hc = cycle_count; m_halted = 1'b1;
         end
         cyc = cyc + 1;
      end
   end

   task automatic do_reset();
      @(negedge clk); clr_n = 1'b0;
      @(negedge clk); clr_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      tests++; if (an_n !== 8'hFF) begin fails++; $display("FAIL reset_an an_n=%h want FF", an_n); end
      tests++; if (seg_n !== 7'h7F) begin fails++; $display("FAIL reset_seg seg_n=%h want 7F", seg_n); end
      tests++; if (dp_n !== 1'b1) begin fails++; $display("FAIL reset_dp dp_n=%b want 1", dp_n); end
      tests++; if (halted_seen !== 1'b0) begin fails++; $display("FAIL reset_halted halted_seen=%b want 0", halted_seen); end
      tests++; if (shown !== 32'h0) begin fails++; $display("FAIL reset_shown shown=%h want 0", shown); end
      display = 32'h1234ABCD; src_sel = 1'b0; clr_n = 1'b1;
   endtask

   task automatic test_first_frame();
      for (int e = 1; e <= 64; e++) begin
         @(negedge clk);
         tests++; if ({an_n, seg_n, dp_n, halted_seen, shown} !== {m_an, m_seg, m_dp, m_halted, m_shown}) begin fails++;
            $display("FAIL first_frame_model cyc=%0d an=%h/%h seg=%h/%h dp=%b/%b hs=%b/%b shown=%h/%h", cyc, an_n, m_an, seg_n, m_seg, dp_n, m_dp, halted_seen, m_halted, shown, m_shown); end
         if (e == 32) begin
            tests++; if (shown !== 32'h1234ABCD) begin fails++; $display("FAIL first_frame_shown shown=%h want 1234ABCD", shown); end
         end
         if (e == 33) begin
            tests++; if ({an_n, seg_n} !== {8'hFE, 7'h21}) begin fails++; $display("FAIL digit0_slot an=%h seg=%h want FE 21", an_n, seg_n); end
         end
         if (e == 61) begin
            tests++; if ({an_n, seg_n} !== {8'h7F, 7'h79}) begin fails++; $display("FAIL digit7_slot an=%h seg=%h want 7F 79", an_n, seg_n); end
         end
      end
   endtask

   task automatic test_mid_frame();
      for (int i = 0; i < FRAME && (cyc % FRAME) != 10; i++) @(negedge clk);
      tests++; if ((cyc % FRAME) != 10) begin fails++; $display("FAIL mid_frame_align cyc=%0d want frame offset 10", cyc); end
      display = 32'h0;
      for (int k = 0; k < 22 + FRAME; k++) begin
         @(negedge clk);
         tests++; if ({an_n, seg_n, dp_n, halted_seen, shown} !== {m_an, m_seg, m_dp, m_halted, m_shown}) begin fails++;
            $display("FAIL mid_frame_model cyc=%0d an=%h/%h seg=%h/%h dp=%b/%b hs=%b/%b shown=%h/%h", cyc, an_n, m_an, seg_n, m_seg, dp_n, m_dp, halted_seen, m_halted, shown, m_shown); end
         if (k < 21) begin
            tests++; if (shown !== 32'h1234ABCD) begin fails++; $display("FAIL mid_frame_hold k=%0d shown=%h want 1234ABCD", k, shown); end
         end else if (k == 21) begin
            tests++; if (shown !== 32'h0) begin fails++; $display("FAIL mid_frame_load shown=%h want 0", shown); end
         end else begin
`ifdef CPU_DISP_BLANK_EN
            tests++; if (seg_n !== ((an_n == 8'hFE) ? 7'h40 : 7'h7F)) begin fails++; $display("FAIL zero_digits an=%h seg=%h", an_n, seg_n); end
`else
            tests++; if (seg_n !== 7'h40) begin fails++; $display("FAIL zero_digits an=%h seg=%h want 40", an_n, seg_n); end
`endif
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8 * FRAME; i++) begin
         @(negedge clk);
         tests++; if ({an_n, seg_n, dp_n, halted_seen, shown} !== {m_an, m_seg, m_dp, m_halted, m_shown}) begin fails++;
            $display("FAIL random_model cyc=%0d an=%h/%h seg=%h/%h dp=%b/%b hs=%b/%b shown=%h/%h", cyc, an_n, m_an, seg_n, m_seg, dp_n, m_dp, halted_seen, m_halted, shown, m_shown); end
         if ($urandom_range(7) == 0) display = $urandom;
         if ($urandom_range(7) == 0) cycle_count = $urandom;
         if ($urandom_range(15) == 0) src_sel = ~src_sel;
         if ($urandom_range(31) == 0) freeze = ~freeze;
      end
      freeze = 1'b0;
   endtask

   task automatic test_halt();
      int stage = 0;
      @(negedge clk); display = 32'h55; cycle_count = 32'h100; src_sel = 1'b1; halt = 1'b1;
      @(negedge clk); halt = 1'b0; display = 32'h99; cycle_count = 32'h777;
      tests++; if (halted_seen !== 1'b1) begin fails++; $display("FAIL halt_seen halted_seen=%b want 1", halted_seen); end
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clk);
         tests++; if ({an_n, seg_n, dp_n, halted_seen, shown} !== {m_an, m_seg, m_dp, m_halted, m_shown}) begin fails++;
            $display("FAIL halt_model cyc=%0d an=%h/%h seg=%h/%h dp=%b/%b hs=%b/%b shown=%h/%h", cyc, an_n, m_an, seg_n, m_seg, dp_n, m_dp, halted_seen, m_halted, shown, m_shown); end
         tests++; if (dp_n === 1'b0 && an_n !== 8'hFE) begin fails++; $display("FAIL halt_dp dp_n=0 with an_n=%h want FE", an_n); end
         if ((cyc % FRAME) == 0 && stage == 0) begin
            tests++; if (shown !== 32'h100) begin fails++; $display("FAIL halt_cyc_shown shown=%h want 100", shown); end
            src_sel = 1'b0; stage = 1;
         end else if ((cyc % FRAME) == 0 && stage == 1) begin
            tests++; if (shown !== 32'h55) begin fails++; $display("FAIL halt_disp_shown shown=%h want 55", shown); end
            stage = 2;
         end
      end
      tests++; if (stage != 2) begin fails++; $display("FAIL halt_timeout stage=%0d want 2", stage); end
   endtask

   task automatic test_freeze();
      @(negedge clk); freeze = 1'b1;
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clk);
         tests++; if (shown !== 32'h55) begin fails++; $display("FAIL freeze_hold cyc=%0d shown=%h want 55", cyc, shown); end
         if ((i % 8) == 0) begin src_sel = ~src_sel; display = $urandom; cycle_count = $urandom; end
      end
      freeze = 1'b0; src_sel = 1'b1;
      for (int i = 0; i < FRAME + 1 && (cyc % FRAME) != 0; i++) @(negedge clk);
      tests++; if (shown !== 32'h100) begin fails++; $display("FAIL freeze_release shown=%h want 100", shown); end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < FRAME && (cyc % FRAME) != 13; i++) @(negedge clk);
      #2 clr_n = 1'b0;
      #1;
      tests++; if ({an_n, seg_n, dp_n, halted_seen, shown} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 32'h0}) begin fails++;
         $display("FAIL async_reset an=%h seg=%h dp=%b hs=%b shown=%h want FF 7F 1 0 0", an_n, seg_n, dp_n, halted_seen, shown); end
      @(negedge clk); clr_n = 1'b1;
   endtask

   task automatic test_halt_on_frame_end();
      src_sel = 1'b0; display = 32'h11112222; cycle_count = 32'h33334444;
      do_reset();
      for (int i = 0; i < FRAME && (cyc % FRAME) != FRAME - 1; i++) @(negedge clk);
      display = 32'hCAFE0001; cycle_count = 32'hBEEF0002; halt = 1'b1;
      @(negedge clk); halt = 1'b0; display = 32'h0; cycle_count = 32'h0; src_sel = 1'b1;
      tests++; if ({halted_seen, shown} !== {1'b1, 32'hCAFE0001}) begin fails++; $display("FAIL halt_fe_run_load hs=%b shown=%h want 1 CAFE0001", halted_seen, shown); end
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         tests++; if ({an_n, seg_n, dp_n, halted_seen, shown} !== {m_an, m_seg, m_dp, m_halted, m_shown}) begin fails++;
            $display("FAIL halt_fe_model cyc=%0d an=%h/%h seg=%h/%h dp=%b/%b hs=%b/%b shown=%h/%h", cyc, an_n, m_an, seg_n, m_seg, dp_n, m_dp, halted_seen, m_halted, shown, m_shown); end
      end
      tests++; if (shown !== 32'hBEEF0002) begin fails++; $display("FAIL halt_fe_snapshot shown=%h want BEEF0002", shown); end
   endtask

   task automatic test_freeze_halt();
      src_sel = 1'b0; display = 32'h0000ABCD; freeze = 1'b1;
      do_reset();
      repeat (5) @(negedge clk);
      halt = 1'b1;
      @(negedge clk); halt = 1'b0; display = 32'h0;
      for (int i = 0; i < FRAME; i++) @(negedge clk);
      tests++; if ({halted_seen, shown} !== {1'b1, 32'h0}) begin fails++; $display("FAIL freeze_halt_hold hs=%b shown=%h want 1 0", halted_seen, shown); end
      freeze = 1'b0;
      for (int i = 0; i < FRAME + 1 && (cyc % FRAME) != 0; i++) @(negedge clk);
      tests++; if (shown !== 32'h0000ABCD) begin fails++; $display("FAIL freeze_halt_capture shown=%h want 0000ABCD", shown); end
   endtask

   task automatic test_blank();
      src_sel = 1'b0; display = 32'h00000007;
      do_reset();
      for (int e = 1; e <= 2 * FRAME; e++) begin
         @(negedge clk);
         tests++; if ({an_n, seg_n, dp_n, halted_seen, shown} !== {m_an, m_seg, m_dp, m_halted, m_shown}) begin fails++;
            $display("FAIL blank_model cyc=%0d an=%h/%h seg=%h/%h dp=%b/%b hs=%b/%b shown=%h/%h", cyc, an_n, m_an, seg_n, m_seg, dp_n, m_dp, halted_seen, m_halted, shown, m_shown); end
         if (e > FRAME) begin
            tests++; if (an_n !== ~(8'd1 << ((e - 1) / CLK_DIV % 8))) begin fails++; $display("FAIL blank_scan e=%0d an=%h", e, an_n); end
`ifdef CPU_DISP_BLANK_EN
            tests++; if (seg_n !== ((an_n == 8'hFE) ? 7'h78 : 7'h7F)) begin fails++; $display("FAIL blank_seg an=%h seg=%h", an_n, seg_n); end
`else
            tests++; if (seg_n !== ((an_n == 8'hFE) ? 7'h78 : 7'h40)) begin fails++; $display("FAIL blank_seg an=%h seg=%h", an_n, seg_n); end
`endif
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_mid_frame();
      test_random();
      test_halt();
      test_freeze();
      test_reset_mid_frame();
      test_halt_on_frame_end();
      test_freeze_halt();
      test_blank();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cpu_disp_driver.md
Name: cpu_disp_driver

Overview:
Board-side consumer of the CPU's `display`, `cycle_count` and `halt` outputs. It drives an 8-digit, time-multiplexed, active-low seven-segment display. A frame-coherent snapshot prevents tearing. A halt-capture FSM freezes the final CPU results so they stay readable after the program stops. It sits at the FPGA top level, beside the cpu instance.

Parameters:
CLK_DIV, 50000, clk cycles per digit slot (must be ≥ 2)
DIGITS, 8, number of multiplexed digits (fixed 8 for a 32-bit value; 4 bits per digit)

Ports:
clk  in  1  system clock, shared with cpu
clr_n  in  1  reset, asynchronous, active-low
display  in  32  CPU syscall display value
cycle_count  in  32  CPU cycle counter
halt  in  1  CPU halt level
src_sel  in  1  0 = show display, 1 = show cycle_count
freeze  in  1  1 = hold the current snapshot
seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
dp_n  out  1  decimal point, active-low
an_n  out  8  digit enables, active-low; bit k = digit k (k = 0 is least significant)
shown  out  32  value currently being displayed
halted_seen  out  1  FSM is in HALTED

Behaviour:
- Reset (clr_n = 0, asynchronous):
  - Prescaler = 0, digit index = 0, shown = 0, halt snapshots = 0, state = RUN.
  - an_n = 8'hFF, seg_n = 7'h7F, dp_n = 1, halted_seen = 0.
- Prescaler and digit index:
  - Prescaler counts 0..CLK_DIV-1 and wraps to 0.
  - tick = (prescaler == CLK_DIV-1).
  - Digit index increments on tick and wraps 7→0.
  - frame_end = tick && (index == 7).
- Snapshot update: on frame_end, if freeze = 0, shown loads the selected source:
  - RUN: display or cycle_count.
  - HALTED: halt_disp or halt_cyc.
  - Otherwise shown holds. Input changes mid-frame are never visible before frame_end.
- FSM, 2 states:
  - RUN: in any cycle with halt = 1, latch halt_disp ← display and halt_cyc ← cycle_count in that same edge, then go to HALTED.
  - HALTED: sticky. Deasserting halt does not leave HALTED; only clr_n does. src_sel still chooses between the two halt snapshots.
  - halted_seen = (state == HALTED), registered.
- Outputs are registered, with 1-cycle latency from index/shown:
  - an_n = ~(1 << index).
  - seg_n = hex decode of shown[4*index+3 : 4*index].
  - dp_n = 0 only when halted_seen && index == 0; otherwise 1.
  - First post-reset cycle shows digit 0.
- Hex decode (seg_n, hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Simultaneous events:
  - halt rising on a frame_end: the capture happens and the frame_end load uses the RUN sources. The halt snapshot appears at the next frame_end.
  - freeze overrides frame_end loads but never blocks halt capture.

Optional Feature:
Macro `CPU_DISP_BLANK_EN`.
- Defined: leading-zero blanking. Any digit k > 0 whose nibble and all higher nibbles of shown are zero drives seg_n = 7'h7F and dp_n = 1. an_n still scans normally. Digit 0 is always decoded.
- Undefined: all 8 digits are always decoded, and the blanking logic is absent.

Decomposition:
- Package `cpu_disp_pkg` holds:
  - the state enum (`DISP_RUN`, `DISP_HALTED`)
  - the 16-entry seg_n constant array
  - the `SEG_BLANK` (7'h7F) constant
- One sub-module: `cpu_disp_hex2seg`, a combinational 4-bit → 7-bit decoder instantiated once on the indexed nibble. Prescaler, FSM and output registers stay in `cpu_disp_driver`.

Test Plan (CLK_DIV = 4):
1. Release clr_n with display = 32'h1234ABCD, src_sel = 0.
   - After the first frame_end (32 cycles), shown = 32'h1234ABCD.
   - Digit 0 slot: an_n = 8'hFE, seg_n = 7'h21.
   - Digit 7 slot: an_n = 8'h7F, seg_n = 7'h79.
2. Set display = 32'h0 at cycle 10 of a frame.
   - shown holds its old value until frame_end, then becomes 0.
   - Every digit then shows seg_n = 7'h40.
3. Hold display = 32'h55 and cycle_count = 32'h100, pulse halt for 1 cycle, then change display to 32'h99.
   - halted_seen = 1 on the next cycle.
   - With src_sel = 1: shown = 32'h100 after the next frame_end.
   - With src_sel = 0: shown = 32'h55 after the following frame_end.
   - dp_n = 0 only in digit 0 slots.
4. Set freeze = 1, then change the source over 3 frames.
   - shown is unchanged throughout.
   - Release freeze → shown updates at the next frame_end.
5. Assert clr_n low mid-frame while HALTED.
   - Outputs are immediately an_n = 8'hFF, seg_n = 7'h7F, halted_seen = 0, shown = 0.
6. With `CPU_DISP_BLANK_EN` defined and shown = 32'h00000007:
   - Digit 0: seg_n = 7'h78.
   - Digits 1–7: seg_n = 7'h7F while an_n keeps scanning.
   - Without the macro, digits 1–7 show 7'h40.
